// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller and address decoders.
// FSM encodings and region-select constants.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam int   REGION_BIT = 15;
    localparam logic REGION_ROM = 1'b0;
    localparam logic REGION_RAM = 1'b1;

endpackage

// File: rtl/mem_addr_decode.sv
// Region decode of a latched word address into RAM/ROM select and truncated addresses.
// Latency: combinational. Backpressure: none.
module mem_addr_decode
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RAM_AW = 7,
    parameter int ROM_AW = 7
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              region,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [ROM_AW-1:0] rom_addr
);

    // Bits between the word address and the region bit are don't-care, so regions alias.
    logic unused_addr_bits;

    assign region           = addr[REGION_BIT];
    assign ram_addr         = addr[RAM_AW-1:0];
    assign rom_addr         = addr[ROM_AW-1:0];
    assign unused_addr_bits = ^{1'b0, addr};

endmodule

// File: rtl/mem_bus_ctrl.sv
// Req/Ack bridge from the processor to synchronous RAM/ROM; blocks and flags ROM writes.
// Latency: write ack after E1, read ack after E(1+MEM_LAT). Backpressure: one transaction at a time, Req held until Ack.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int RAM_AW  = 7,
    parameter int ROM_AW  = 7,
    parameter int MEM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              W,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    output logic              Busy,
    output logic              ErrWrRom,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                w_q, w_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wren_q, wren_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          lat_cnt_q, lat_cnt_d;
    logic                region;

    mem_addr_decode #(
        .ADDR_W (ADDR_W),
        .RAM_AW (RAM_AW),
        .ROM_AW (ROM_AW)
    ) u_decode (
        .addr     (addr_q),
        .region   (region),
        .ram_addr (ram_addr),
        .rom_addr (rom_addr)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        w_d       = w_q;
        wdata_d   = wdata_q;
        wren_d    = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d  = Addr;
                    w_d     = W;
                    wdata_d = WData;
                    // Strobe is registered so it lines up with the ACCESS cycle.
                    wren_d  = W && (Addr[REGION_BIT] == REGION_RAM);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                lat_cnt_d = '0;
                if (w_q) begin
                    if (region == REGION_ROM) begin
                        err_d = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rdata_d = (region == REGION_RAM) ? ram_q : rom_q;
                    state_d = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            w_q       <= 1'b0;
            wdata_q   <= '0;
            wren_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            w_q       <= w_d;
            wdata_q   <= wdata_d;
            wren_q    <= wren_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign Ack      = (state_q == S_RESP);
    assign Busy     = (state_q != S_IDLE);
    assign ErrWrRom = err_q;
    assign RData    = rdata_q;
    assign ram_data = wdata_q;
    assign ram_wren = wren_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench: two controllers (MEM_LAT=1 and MEM_LAT=2), each with its own RAM/ROM model.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        req1  = 1'b0;
    logic        req2  = 1'b0;
    logic        w     = 1'b0;
    logic [15:0] addr  = '0;
    logic [15:0] wdata = '0;

    logic        ack1, busy1, err1, ram_wren1;
    logic [15:0] rdata1, ram_data1, ram_q1, rom_q1;
    logic [6:0]  ram_addr1, rom_addr1;
    logic        ack2, busy2, err2, ram_wren2;
    logic [15:0] rdata2, ram_data2, ram_q2, rom_q2;
    logic [6:0]  ram_addr2, rom_addr2;

    mem_bus_ctrl #(.MEM_LAT(1)) dut1 (
        .Clock(clk), .Reset(reset), .Req(req1), .W(w), .Addr(addr), .WData(wdata),
        .Ack(ack1), .RData(rdata1), .Busy(busy1), .ErrWrRom(err1),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_wren(ram_wren1), .ram_q(ram_q1),
        .rom_addr(rom_addr1), .rom_q(rom_q1)
    );

    mem_bus_ctrl #(.MEM_LAT(2)) dut2 (
        .Clock(clk), .Reset(reset), .Req(req2), .W(w), .Addr(addr), .WData(wdata),
        .Ack(ack2), .RData(rdata2), .Busy(busy2), .ErrWrRom(err2),
        .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_wren(ram_wren2), .ram_q(ram_q2),
        .rom_addr(rom_addr2), .rom_q(rom_q2)
    );

    function automatic logic [15:0] rom_val(input logic [6:0] a);
        return (a == 7'd3) ? 16'h1234 : {8'hA5, 1'b0, a};
    endfunction

    // Memory models: address registered at the edge ending ACCESS, MEM_LAT-1 extra output stages.
    logic [15:0] ram1 [128];
    logic [15:0] ram2 [128];
    logic [6:0]  ram_ar1 = '0, rom_ar1 = '0, ram_ar2 = '0, rom_ar2 = '0;
    logic [15:0] ram_q2_r = '0, rom_q2_r = '0;

    always @(posedge clk) begin
        if (ram_wren1) ram1[ram_addr1] <= ram_data1;
        ram_ar1 <= ram_addr1;
        rom_ar1 <= rom_addr1;
        if (ram_wren2) ram2[ram_addr2] <= ram_data2;
        ram_ar2  <= ram_addr2;
        rom_ar2  <= rom_addr2;
        ram_q2_r <= ram2[ram_ar2];
        rom_q2_r <= rom_val(rom_ar2);
    end

    assign ram_q1 = ram1[ram_ar1];
    assign rom_q1 = rom_val(rom_ar1);
    assign ram_q2 = ram_q2_r;
    assign rom_q2 = rom_q2_r;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_cyc;
    int          wren_cnt;
    logic [15:0] got_rdata;
    logic [15:0] wren_data;
    logic [6:0]  wren_addr;

    // Issues one transaction from a negedge; ack_cyc = negedge index (1 = cycle after E0) where Ack was seen.
    task automatic issue(input bit sel, input logic wr, input logic [15:0] a, input logic [15:0] d);
        int guard;
        guard = 0;
        while ((sel ? busy2 : busy1) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        w = wr; addr = a; wdata = d;
        if (sel) req2 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        ack_cyc  = 0;
        wren_cnt = 0;
        #1;
        w = ~wr; addr = ~a; wdata = ~d;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sel ? ram_wren2 : ram_wren1) begin
                wren_cnt++;
                wren_addr = sel ? ram_addr2 : ram_addr1;
                wren_data = sel ? ram_data2 : ram_data1;
            end
            if (sel ? ack2 : ack1) begin
                ack_cyc   = c;
                got_rdata = sel ? rdata2 : rdata1;
                req1 = 1'b0;
                req2 = 1'b0;
                break;
            end
        end
        req1 = 1'b0;
        req2 = 1'b0;
        n_checks++;
        if (ack_cyc == 0) begin
            n_fail++;
            $display("FAIL issue_timeout addr=%h: no Ack within 20 cycles", a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req1 = 1'b1; req2 = 1'b1; w = 1'b0; addr = 16'h0003; wdata = 16'h5555;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack1, busy1, busy2, ram_wren1, err1} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl ack/busy1/busy2/wren/err got=%b exp=00000",
                     {ack1, busy1, busy2, ram_wren1, err1});
        end
        n_checks++;
        if ({rdata1, ram_data1} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data rdata/ram_data got=%h exp=00000000", {rdata1, ram_data1});
        end
        n_checks++;
        if ({ram_addr1, rom_addr1} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_addr ram/rom addr got=%h exp=0000", {ram_addr1, rom_addr1});
        end
        reset = 1'b0;
        req2  = 1'b0;
        issue(1'b0, 1'b0, 16'h0003, 16'h0);
        n_checks++;
        if (ack_cyc != 3) begin
            n_fail++;
            $display("FAIL reset_release_ack_cycle got=%0d exp=3", ack_cyc);
        end
        n_checks++;
        if (got_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL reset_release_rdata got=%h exp=1234", got_rdata);
        end
    endtask

    task automatic test_ram_write_read();
        issue(1'b0, 1'b1, 16'h8005, 16'hBEEF);
        n_checks++;
        if (ack_cyc != 2) begin
            n_fail++;
            $display("FAIL ram_wr_ack_cycle got=%0d exp=2", ack_cyc);
        end
        n_checks++;
        if (wren_cnt != 1) begin
            n_fail++;
            $display("FAIL ram_wr_wren_cycles got=%0d exp=1", wren_cnt);
        end
        n_checks++;
        if ({wren_addr, wren_data} !== {7'd5, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL ram_wr_port addr/data got=%0d/%h exp=5/beef", wren_addr, wren_data);
        end
        n_checks++;
        if (err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ram_wr_err got=%b exp=0", err1);
        end
        issue(1'b0, 1'b0, 16'h8005, 16'h0);
        n_checks++;
        if (ack_cyc != 3 || got_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ram_rd cycle/rdata got=%0d/%h exp=3/beef", ack_cyc, got_rdata);
        end
        issue(1'b0, 1'b0, 16'hFF85, 16'h0);
        n_checks++;
        if (got_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ram_alias_rd got=%h exp=beef", got_rdata);
        end
    endtask

    task automatic test_rom_read();
        issue(1'b0, 1'b0, 16'h0003, 16'h0);
        n_checks++;
        if (ack_cyc != 3 || got_rdata !== 16'h1234 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_rd_lat1 cycle/rdata/err got=%0d/%h/%b exp=3/1234/0", ack_cyc, got_rdata, err1);
        end
        issue(1'b0, 1'b0, 16'h7F87, 16'h0);
        n_checks++;
        if (got_rdata !== 16'hA507) begin
            n_fail++;
            $display("FAIL rom_alias_rd got=%h exp=a507", got_rdata);
        end
        issue(1'b1, 1'b0, 16'h0003, 16'h0);
        n_checks++;
        if (ack_cyc != 4 || got_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL rom_rd_lat2 cycle/rdata got=%0d/%h exp=4/1234", ack_cyc, got_rdata);
        end
    endtask

    task automatic test_rom_write();
        issue(1'b0, 1'b1, 16'h0010, 16'h1111);
        n_checks++;
        if (ack_cyc != 2 || wren_cnt != 0) begin
            n_fail++;
            $display("FAIL rom_wr cycle/wren_cycles got=%0d/%0d exp=2/0", ack_cyc, wren_cnt);
        end
        n_checks++;
        if (err1 !== 1'b1 || rdata1 !== 16'hA507) begin
            n_fail++;
            $display("FAIL rom_wr err/rdata_hold got=%b/%h exp=1/a507", err1, rdata1);
        end
        issue(1'b0, 1'b0, 16'h8005, 16'h0);
        n_checks++;
        if (got_rdata !== 16'hBEEF || err1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rom_wr_sticky rdata/err got=%h/%b exp=beef/1", got_rdata, err1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err1 !== 1'b0 || rdata1 !== 16'h0) begin
            n_fail++;
            $display("FAIL rom_wr_reset err/rdata got=%b/%h exp=0/0000", err1, rdata1);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_addr [4] = '{16'h0003, 16'h8005, 16'h0007, 16'h8005};
        logic [15:0] exp_data [4] = '{16'h1234, 16'hBEEF, 16'hA507, 16'hBEEF};
        int k;
        int last;
        k = 0;
        last = 0;
        @(negedge clk);
        w = 1'b0; addr = exp_addr[0]; req1 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ack1) begin
                n_checks++;
                if (rdata1 !== exp_data[k]) begin
                    n_fail++;
                    $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, rdata1, exp_data[k]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (c - last != 4) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d] got=%0d exp=4", k, c - last);
                    end
                end
                last = c;
                k++;
                if (k == 4) break;
                addr = exp_addr[k];
            end
        end
        req1 = 1'b0;
        n_checks++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=4", k);
        end
    endtask

    task automatic test_reset_mid();
        logic any_ack;
        @(negedge clk);
        w = 1'b0; addr = 16'h8005; req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_in_wait got=%b exp=1", busy1);
        end
        reset = 1'b1;
        req1  = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy1, ack1} !== 2'b00 || rdata1 !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_abort busy/ack/rdata got=%b%b/%h exp=00/0000", busy1, ack1, rdata1);
        end
        reset = 1'b0;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_ack = any_ack | ack1;
        end
        n_checks++;
        if (any_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_ack got=%b exp=0", any_ack);
        end
        issue(1'b0, 1'b0, 16'h8005, 16'h0);
        n_checks++;
        if (ack_cyc != 3 || got_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL mid_fresh_rd cycle/rdata got=%0d/%h exp=3/beef", ack_cyc, got_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_ram_write_read();
        test_rom_read();
        test_rom_write();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
